// File: rtl/clk_div_ctrl.sv
// Run-time clock-division controller: per-period tick, phase level and a boundary-synchronised ratio update.
// Optional completed-period counter built when CLK_DIV_CTRL_CNT_EN is defined.
module clk_div_ctrl #(
  parameter int unsigned MAX_RATIO   = 1024,
  parameter int unsigned RESET_RATIO = 2,
  localparam int unsigned W          = $clog2(MAX_RATIO + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_ratio,
  output logic         cfg_ready,
  output logic         tick,
  output logic         phase,
  output logic         busy,
  output logic         err,
  output logic [31:0]  periods
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   ratio, ratio_nxt;
  logic [W-1:0]   count, count_nxt;
  logic [W-1:0]   pend_ratio, pend_ratio_nxt;
  logic           pend, pend_nxt;
  logic           err_q, err_nxt;
  logic           last_c;
  logic           xfer_c;
  logic           legal_c;

  assign last_c  = (count == ratio - W'(1));
  assign xfer_c  = cfg_valid && !pend;
  assign legal_c = (cfg_ratio >= W'(2)) && (cfg_ratio <= W'(MAX_RATIO));

  // Outputs decode registered state only.
  assign cfg_ready = !pend;
  assign busy      = (state != IDLE);
  assign tick      = (state != IDLE) && last_c;
  assign phase     = (state != IDLE) && (count < (ratio >> 1));
  assign err       = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      ratio      <= W'(RESET_RATIO);
      count      <= '0;
      pend       <= 1'b0;
      pend_ratio <= '0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      ratio      <= ratio_nxt;
      count      <= count_nxt;
      pend       <= pend_nxt;
      pend_ratio <= pend_ratio_nxt;
      err_q      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    ratio_nxt      = ratio;
    count_nxt      = count;
    pend_nxt       = pend;
    pend_ratio_nxt = pend_ratio;
    err_nxt        = err_q;

    case (state)
      IDLE: begin
        count_nxt = '0;
        if (enable) state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (last_c) begin
          // Period boundary: the only place a pended ratio takes effect.
          count_nxt = '0;
          if (pend) begin
            ratio_nxt = pend_ratio;
            pend_nxt  = 1'b0;
          end
          state_nxt = enable ? RUN : IDLE;
        end else begin
          count_nxt = W'(count + W'(1));
          state_nxt = enable ? RUN : DRAIN;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase

    // A pend set here can never collide with the boundary clear: xfer requires pend==0.
    if (xfer_c) begin
      if (legal_c) begin
        err_nxt = 1'b0;
        if (state == IDLE) begin
          ratio_nxt = cfg_ratio;
        end else begin
          pend_nxt       = 1'b1;
          pend_ratio_nxt = cfg_ratio;
        end
      end else begin
        err_nxt = 1'b1;
      end
    end
  end

`ifdef CLK_DIV_CTRL_CNT_EN
  logic [31:0] periods_q;

  always_ff @(posedge clock) begin
    if (reset) periods_q <= '0;
    else if (tick) periods_q <= periods_q + 32'd1;
  end

  assign periods = periods_q;
`else
  assign periods = '0;
`endif

endmodule
